pool_psum_rd: RTL and testbench

//  Read-side initiator for the PE-array psum store: walks every PEB and psum address

---
 rtl/pool_psum_rd_pkg.sv | 47 ++++
 rtl/pool_psum_rd_if.sv | 28 ++
 rtl/pool_psum_rd_lane.sv | 25 ++
 rtl/pool_psum_rd.sv | 178 +++++++++++++++++
 tb/tb_pool_psum_rd.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pool_psum_rd_pkg.sv
// Shared types and constants for the psum read / pooling block.
package pool_psum_rd_pkg;

  // Ceiling log2, usable in constant expressions.
  function automatic int c_log_2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  localparam int NUMPEB        = 16;
  localparam int LENPSUM       = 16;
  localparam int DATA_WIDTH    = 8;
  localparam int CHANNEL_DEPTH = 32;
  localparam int PSUM_WIDTH    = DATA_WIDTH * 2 + c_log_2(CHANNEL_DEPTH) + 2;
  localparam int AW            = c_log_2(LENPSUM);
  localparam int PW            = c_log_2(NUMPEB);
  localparam int SHW           = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  // One processed row; element 0 sits at the LSBs.
  typedef logic [LENPSUM-1:0][DATA_WIDTH-1:0] row_t;

  typedef struct packed {
    row_t            dat;
    logic [PW-1:0]   peb;
    logic [AW-1:0]   addr;
  } result_t;

  // Lane-wise unsigned maximum of two rows.
  function automatic row_t row_max(input row_t x, input row_t y);
    row_t r;
    for (int i = 0; i < LENPSUM; i++) begin
      r[i] = (x[i] > y[i]) ? x[i] : y[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/pool_psum_rd_if.sv
// PE-array read port and output-activation writer port of the pooling block.
interface pool_psum_rd_if;
  import pool_psum_rd_pkg::*;

  logic [NUMPEB-1:0]             POOLPEB_EnRd;
  logic [AW-1:0]                 POOLPEB_AddrRd;
  logic [PSUM_WIDTH*LENPSUM-1:0] PEBPOOL_Dat;
  logic                          POOLWR_Val;
  logic                          WRPOOL_Rdy;
  logic [DATA_WIDTH*LENPSUM-1:0] POOLWR_Dat;
  logic [PW-1:0]                 POOLWR_PEB;
  logic [AW-1:0]                 POOLWR_Addr;

  modport master (
    output POOLPEB_EnRd, POOLPEB_AddrRd,
    input  PEBPOOL_Dat,
    output POOLWR_Val, POOLWR_Dat, POOLWR_PEB, POOLWR_Addr,
    input  WRPOOL_Rdy
  );

  modport slave (
    input  POOLPEB_EnRd, POOLPEB_AddrRd,
    output PEBPOOL_Dat,
    input  POOLWR_Val, POOLWR_Dat, POOLWR_PEB, POOLWR_Addr,
    output WRPOOL_Rdy
  );

endinterface

// File: rtl/pool_psum_rd_lane.sv
// One psum lane: ReLU, arithmetic right shift, unsigned saturation.
module pool_lane
  import pool_psum_rd_pkg::*;
(
  input  logic signed [PSUM_WIDTH-1:0] psum_i,
  input  logic        [SHW-1:0]        shift_i,
  output logic        [DATA_WIDTH-1:0] act_o
);

  logic signed [PSUM_WIDTH-1:0] shifted;

  // Clamp negatives to zero, then scale down and saturate to the activation range.
  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    shifted = psum_i >>> shift_i;
    if (psum_i[PSUM_WIDTH-1]) begin
      act_o = '0;
    end else if (|shifted[PSUM_WIDTH-1:DATA_WIDTH]) begin
      act_o = '1;
    end else begin
      act_o = shifted[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/pool_psum_rd.sv
// Psum store read initiator: walks PEBs/addresses, post-processes rows,
// optionally max-pools address pairs and streams results through a 2-entry FIFO.
module pool_psum_rd
  import pool_psum_rd_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           CTRLPOOL_Start,
  input  logic           CTRLPOOL_PoolEn,
  input  logic [SHW-1:0] CTRLPOOL_Shift,
  input  logic [AW:0]    CTRLPOOL_NumAddr,
  output logic           POOLCTRL_Busy,
  output logic           POOLCTRL_Done,
  pool_psum_rd_if.master bus
);

  // Control / configuration state
  state_e         state_q;
  logic           pool_en_q;
  logic [SHW-1:0] shift_q;
  logic [AW:0]    num_addr_q;
  logic [PW-1:0]  p_q;
  logic [AW-1:0]  a_q;
  logic           busy_q;
  logic           done_q;

  // Read-return tracking and pooling state
  logic           inflight_q;
  logic [PW-1:0]  rd_p_q;
  logic [AW-1:0]  rd_a_q;
  row_t           pool_reg_q, pool_reg_d;
  logic           pool_vld_q, pool_vld_d;

  // Output FIFO
  result_t        fifo_q [2];
  logic           wr_ptr_q, rd_ptr_q;
  logic [1:0]     cnt_q, cnt_d;

  row_t           proc_row;
  result_t        push_ent;
  logic           push, pop, issue;
  logic           last_addr, last_issue, rd_last, fin;
  logic [2:0]     credit;

  for (genvar i = 0; i < LENPSUM; i++) begin : g_lane
    pool_lane u_lane (
      .psum_i  (bus.PEBPOOL_Dat[i*PSUM_WIDTH +: PSUM_WIDTH]),
      .shift_i (shift_q),
      .act_o   (proc_row[i])
    );
  end

  // Credit counts the FIFO occupancy after this cycle's pop plus the read in flight,
  // so a draining FIFO keeps the read port busy every cycle.
  assign pop        = (cnt_q != 2'd0) && bus.WRPOOL_Rdy;
  assign credit     = {1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue      = (state_q == S_READ) && (credit < 3'd2);
  assign last_addr  = ({1'b0, a_q} == num_addr_q - (AW+1)'(1));
  assign last_issue = last_addr && (p_q == PW'(NUMPEB - 1));
  assign rd_last    = ({1'b0, rd_a_q} == num_addr_q - (AW+1)'(1));

  // Decide what the returning row does: push directly, park in pool_reg, or pool and push.
  always_comb begin
    push       = 1'b0;
    push_ent   = '0;
    pool_reg_d = pool_reg_q;
    pool_vld_d = pool_vld_q;
    if (inflight_q) begin
      push_ent.peb = rd_p_q;
      if (!pool_en_q) begin
        push          = 1'b1;
        push_ent.dat  = proc_row;
        push_ent.addr = rd_a_q;
      end else if (!rd_a_q[0] && !rd_last) begin
        pool_reg_d = proc_row;
        pool_vld_d = 1'b1;
      end else begin
        push          = 1'b1;
        push_ent.addr = rd_a_q >> 1;
        push_ent.dat  = rd_a_q[0] ? row_max(pool_reg_q, proc_row) : proc_row;
        pool_vld_d    = 1'b0;
      end
    end
  end

  assign cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  assign fin   = (state_q == S_DRAIN) && !inflight_q && (cnt_d == 2'd0) && !pool_vld_d;

  // Sequencer: config latch, PEB/address walk and the Busy/Done handshake.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pool_en_q  <= 1'b0;
      shift_q    <= '0;
      num_addr_q <= '0;
      p_q        <= '0;
      a_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (CTRLPOOL_Start) begin
            pool_en_q  <= CTRLPOOL_PoolEn;
            shift_q    <= CTRLPOOL_Shift;
            num_addr_q <= CTRLPOOL_NumAddr;
            p_q        <= '0;
            a_q        <= '0;
            busy_q     <= 1'b1;
            state_q    <= S_READ;
          end
        end
        S_READ: begin
          if (issue) begin
            if (last_addr) begin
              a_q <= '0;
              p_q <= p_q + PW'(1);
            end else begin
              a_q <= a_q + AW'(1);
            end
            if (last_issue) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (fin) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Datapath: in-flight tag, pooling register and the 2-entry result FIFO.
  // NOTE: the FIFO storage is only two entries and drives outputs, so it is reset along with the pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= 1'b0;
      rd_p_q     <= '0;
      rd_a_q     <= '0;
      pool_reg_q <= '0;
      pool_vld_q <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        rd_p_q <= p_q;
        rd_a_q <= a_q;
      end
      pool_reg_q <= pool_reg_d;
      pool_vld_q <= pool_vld_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= push_ent;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_d;
    end
  end

  assign bus.POOLPEB_EnRd   = issue ? (NUMPEB'(1) << (PW'(NUMPEB - 1) - p_q)) : '0;
  assign bus.POOLPEB_AddrRd = issue ? a_q : '0;
  assign bus.POOLWR_Val     = (cnt_q != 2'd0);
  assign bus.POOLWR_Dat     = fifo_q[rd_ptr_q].dat;
  assign bus.POOLWR_PEB     = fifo_q[rd_ptr_q].peb;
  assign bus.POOLWR_Addr    = fifo_q[rd_ptr_q].addr;
  assign POOLCTRL_Busy      = busy_q;
  assign POOLCTRL_Done      = done_q;

endmodule

// File: tb/tb_pool_psum_rd.sv
// Directed bench for pool_psum_rd: PEB read responder, result scoreboard, stall and reset scenarios.
module tb_pool_psum_rd;
  import pool_psum_rd_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       pool_en;
  logic [4:0] shift;
  logic [4:0] num_addr;
  logic       busy, done;
  int         checks = 0;
  int         errors = 0;

  pool_psum_rd_if bus ();

  pool_psum_rd dut (
    .clk              (clk),
    .rst              (rst),
    .CTRLPOOL_Start   (start),
    .CTRLPOOL_PoolEn  (pool_en),
    .CTRLPOOL_Shift   (shift),
    .CTRLPOOL_NumAddr (num_addr),
    .POOLCTRL_Busy    (busy),
    .POOLCTRL_Done    (done),
    .bus              (bus)
  );

  always #5 clk = ~clk;

  // Raw psum presented on lane i for PEB p, address a.
  function automatic int make_psum(input int mode, input int p, input int a, input int i);
    case (mode)
      0: return i * 256;
      1: case (i % 4)
           0: return -5;
           1: return 1 << 20;
           2: return 'h7F0;
           default: return i * 16 + a;
         endcase
      2: case (a)
           0: return 10 + i;
           1: return 30 + i;
           2: return 50 + i;
           default: return 20 + i;
         endcase
      3: case (a)
           0: return 40 - i;
           1: return 25 + i;
           default: return 7 + p;
         endcase
      default: return ((p * 7 + a * 3 + i) % 256) * 256;
    endcase
  endfunction

  function automatic logic [PSUM_WIDTH*LENPSUM-1:0] make_row(input int mode, input int p, input int a);
    logic [PSUM_WIDTH*LENPSUM-1:0] r;
    int v;
    for (int i = 0; i < LENPSUM; i++) begin
      v = make_psum(mode, p, a, i);
      r[i*PSUM_WIDTH +: PSUM_WIDTH] = v[PSUM_WIDTH-1:0];
    end
    return r;
  endfunction

  // Reference lane: ReLU, divide by 2^shift, clamp to 255.
  function automatic logic [7:0] ref_lane(input int psum, input int sh);
    longint v;
    if (psum < 0) return 8'd0;
    v = longint'(psum) / (longint'(1) << sh);
    if (v > 255) return 8'd255;
    return v[7:0];
  endfunction

  task automatic run_pass(input string name, input bit pen, input logic [4:0] sh,
                          input logic [4:0] na, input int mode, input bit stall,
                          input int rst_at, input bit check_rate);
    logic [DATA_WIDTH*LENPSUM-1:0] exp_dat [$];
    logic [PW-1:0]                 exp_peb [$];
    logic [AW-1:0]                 exp_addr [$];
    logic [DATA_WIDTH*LENPSUM-1:0] r, hold, m, e_dat, held_dat;
    logic [PW-1:0]                 e_peb, held_peb;
    logic [AW-1:0]                 e_addr, held_addr;
    logic [PSUM_WIDTH*LENPSUM-1:0] pend_row;
    logic [NUMPEB-1:0]             exp_en;
    int ip, ia, nreads, nres, ndone, n_exp, last_acc, first_acc, done_cyc, low_run, rst_cyc;
    bit pend, held, finished;

    hold = '0;
    for (int p = 0; p < NUMPEB; p++) begin
      for (int a = 0; a < int'(na); a++) begin
        for (int i = 0; i < LENPSUM; i++) r[i*8 +: 8] = ref_lane(make_psum(mode, p, a, i), int'(sh));
        if (!pen) begin
          exp_dat.push_back(r); exp_peb.push_back(PW'(p)); exp_addr.push_back(AW'(a));
        end else if (a % 2 == 0 && a != int'(na) - 1) begin
          hold = r;
        end else if (a % 2 == 0) begin
          exp_dat.push_back(r); exp_peb.push_back(PW'(p)); exp_addr.push_back(AW'(a / 2));
        end else begin
          for (int i = 0; i < LENPSUM; i++) m[i*8 +: 8] = (hold[i*8 +: 8] > r[i*8 +: 8]) ? hold[i*8 +: 8] : r[i*8 +: 8];
          exp_dat.push_back(m); exp_peb.push_back(PW'(p)); exp_addr.push_back(AW'(a / 2));
        end
      end
    end
    n_exp = exp_dat.size();

    ip = 0; ia = 0; nreads = 0; nres = 0; ndone = 0; low_run = 0;
    last_acc = -10; first_acc = -1; done_cyc = -1; rst_cyc = -1;
    pend = 0; held = 0; finished = 0; pend_row = '0;
    held_dat = '0; held_peb = '0; held_addr = '0;

    @(posedge clk); #1;
    start = 1'b1; pool_en = pen; shift = sh; num_addr = na; bus.WRPOOL_Rdy = 1'b1;

    for (int cyc = 0; cyc < 5000 && !finished; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        checks++;
        if (busy !== 1'b1) $display("FAIL %s busy_after_start: got %b expected 1", name, busy);
        if (busy !== 1'b1) errors++;
      end
      if (stall && !pen) begin
        low_run = bus.WRPOOL_Rdy ? 0 : low_run + 1;
        if (low_run >= 3) begin
          checks++;
          if (bus.POOLPEB_EnRd !== '0) begin
            errors++;
            $display("FAIL %s enrd_while_full: cycle %0d EnRd=%h expected 0", name, cyc, bus.POOLPEB_EnRd);
          end
        end
      end
      // Read port: order, one-hot encoding and address.
      if (bus.POOLPEB_EnRd !== '0) begin
        checks++;
        exp_en = {1'b1, {(NUMPEB-1){1'b0}}} >> ip;
        if (ip >= NUMPEB || bus.POOLPEB_EnRd !== exp_en || bus.POOLPEB_AddrRd !== AW'(ia)) begin
          errors++;
          $display("FAIL %s read_seq: read %0d EnRd=%h Addr=%0d expected EnRd=%h Addr=%0d",
                   name, nreads, bus.POOLPEB_EnRd, bus.POOLPEB_AddrRd, exp_en, ia);
        end
        pend = 1'b1;
        pend_row = make_row(mode, ip, ia);
        nreads++;
        ia++;
        if (ia == int'(na)) begin ia = 0; ip++; end
      end else begin
        pend = 1'b0;
      end
      // Writer side: stalled data must hold.
      if (held) begin
        checks++;
        if (bus.POOLWR_Val !== 1'b1 || bus.POOLWR_Dat !== held_dat ||
            bus.POOLWR_PEB !== held_peb || bus.POOLWR_Addr !== held_addr) begin
          errors++;
          $display("FAIL %s stall_hold: Val=%b Dat=%h PEB=%0d Addr=%0d expected Val=1 Dat=%h PEB=%0d Addr=%0d",
                   name, bus.POOLWR_Val, bus.POOLWR_Dat, bus.POOLWR_PEB, bus.POOLWR_Addr,
                   held_dat, held_peb, held_addr);
        end
      end
      held = bus.POOLWR_Val && !bus.WRPOOL_Rdy;
      held_dat = bus.POOLWR_Dat; held_peb = bus.POOLWR_PEB; held_addr = bus.POOLWR_Addr;
      if (bus.POOLWR_Val === 1'b1 && bus.WRPOOL_Rdy === 1'b1) begin
        checks++;
        if (exp_dat.size() == 0) begin
          errors++;
          $display("FAIL %s extra_result: PEB=%0d Addr=%0d expected none", name, bus.POOLWR_PEB, bus.POOLWR_Addr);
        end else begin
          e_dat = exp_dat.pop_front(); e_peb = exp_peb.pop_front(); e_addr = exp_addr.pop_front();
          if (bus.POOLWR_Dat !== e_dat || bus.POOLWR_PEB !== e_peb || bus.POOLWR_Addr !== e_addr) begin
            errors++;
            $display("FAIL %s result %0d: Dat=%h PEB=%0d Addr=%0d expected Dat=%h PEB=%0d Addr=%0d",
                     name, nres, bus.POOLWR_Dat, bus.POOLWR_PEB, bus.POOLWR_Addr, e_dat, e_peb, e_addr);
          end
        end
        if (first_acc < 0) first_acc = cyc;
        nres++;
        last_acc = cyc;
      end
      if (done === 1'b1) begin
        ndone++;
        checks++;
        if (cyc != last_acc + 1 || exp_dat.size() != 0 || busy !== 1'b0 || ndone != 1) begin
          errors++;
          $display("FAIL %s done_timing: cycle %0d busy=%b pending=%0d count=%0d expected cycle %0d busy=0 pending=0 count=1",
                   name, cyc, busy, exp_dat.size(), ndone, last_acc + 1);
        end
        done_cyc = cyc;
      end
      // Mid-pass reset at the requested read.
      if (rst_at > 0 && rst_cyc < 0 && nreads == rst_at) begin
        rst = 1'b1;
        #1;
        checks++;
        if (bus.POOLPEB_EnRd !== '0 || bus.POOLWR_Val !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL %s reset_outputs: EnRd=%h Val=%b Busy=%b expected 0 0 0",
                   name, bus.POOLPEB_EnRd, bus.POOLWR_Val, busy);
        end
        rst_cyc = cyc;
        pend = 1'b0;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) finished = 1;
      if (rst_cyc >= 0 && cyc >= rst_cyc + 6) finished = 1;

      @(posedge clk); #1;
      start = (cyc == 9);
      if (cyc == 0) begin
        pool_en = ~pen; shift = sh ^ 5'd3; num_addr = 5'd1;
      end
      bus.PEBPOOL_Dat = pend ? pend_row : '0;
      if (stall) bus.WRPOOL_Rdy = (cyc >= 30 && cyc < 50) ? 1'b0 : 1'($urandom_range(0, 1));
      else       bus.WRPOOL_Rdy = 1'b1;
      if (rst_cyc >= 0) rst = 1'b0;
    end
    start = 1'b0;
    bus.WRPOOL_Rdy = 1'b1;

    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL %s timeout: reads=%0d results=%0d done=%0d expected pass to complete", name, nreads, nres, ndone);
    end
    if (rst_at > 0) begin
      checks++;
      if (ndone != 0) begin
        errors++;
        $display("FAIL %s done_after_reset: got %0d pulses expected 0", name, ndone);
      end
    end else begin
      checks++;
      if (nreads != NUMPEB * int'(na) || nres != n_exp || ndone != 1) begin
        errors++;
        $display("FAIL %s totals: reads=%0d results=%0d done=%0d expected %0d %0d 1",
                 name, nreads, nres, ndone, NUMPEB * int'(na), n_exp);
      end
      if (check_rate) begin
        checks++;
        if (last_acc - first_acc != nres - 1 || first_acc != 3) begin
          errors++;
          $display("FAIL %s throughput: first=%0d last=%0d results=%0d expected first=3 back-to-back",
                   name, first_acc, last_acc, nres);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.POOLPEB_EnRd !== '0 || bus.POOLPEB_AddrRd !== '0) begin
      errors++;
      $display("FAIL reset_read_port: EnRd=%h Addr=%h expected 0 0", bus.POOLPEB_EnRd, bus.POOLPEB_AddrRd);
    end
    checks++;
    if (bus.POOLWR_Val !== 1'b0 || bus.POOLWR_Dat !== '0 || bus.POOLWR_PEB !== '0 || bus.POOLWR_Addr !== '0) begin
      errors++;
      $display("FAIL reset_writer_port: Val=%b Dat=%h PEB=%h Addr=%h expected all 0",
               bus.POOLWR_Val, bus.POOLWR_Dat, bus.POOLWR_PEB, bus.POOLWR_Addr);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: Busy=%b Done=%b expected 0 0", busy, done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    run_pass("basic", 1'b0, 5'd8, 5'd16, 0, 1'b0, 0, 1'b1);
  endtask

  task automatic test_saturate();
    run_pass("saturate", 1'b0, 5'd4, 5'd2, 1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_pool_even();
    run_pass("pool_even", 1'b1, 5'd0, 5'd4, 2, 1'b0, 0, 1'b0);
  endtask

  task automatic test_pool_odd();
    run_pass("pool_odd", 1'b1, 5'd0, 5'd3, 3, 1'b0, 0, 1'b0);
  endtask

  task automatic test_stall();
    run_pass("stall", 1'b0, 5'd8, 5'd16, 4, 1'b1, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    run_pass("reset_mid", 1'b0, 5'd8, 5'd16, 4, 1'b0, 40, 1'b0);
    run_pass("after_reset", 1'b0, 5'd8, 5'd16, 4, 1'b0, 0, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    pool_en = 1'b0;
    shift = '0;
    num_addr = 5'd16;
    bus.WRPOOL_Rdy = 1'b1;
    bus.PEBPOOL_Dat = '0;
    test_reset();
    test_basic();
    test_saturate();
    test_pool_even();
    test_pool_odd();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
